// File: rtl/hv_binarizer.sv
// Sign-thresholding binarizer: accumulates bipolar lane contributions per bundle, emits one bit per lane.
// Optional HV_BIN_TIE_LFSR_EN breaks zero-sum ties with a 16-bit LFSR instead of resolving them to 0.

module hv_binarizer_lane #(
    parameter int ACC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             add,
    input  logic [1:0]       code,
    output logic             neg,
    output logic             zero
);
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (ACC_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX;

    logic signed [ACC_W-1:0] acc, acc_nxt, base, step;
    logic signed [ACC_W:0]   sum;

    always_comb begin
        base = clr ? '0 : acc;
        // code 10 (-2) is not a legal contribution and counts as zero
        case (code)
            2'b01:   step = ACC_W'(1);
            2'b11:   step = -ACC_W'(1);
            default: step = '0;
        endcase
        sum     = $signed({base[ACC_W-1], base}) + $signed({step[ACC_W-1], step});
        acc_nxt = base;
        if (add) begin
            if (sum > SAT_MAX)      acc_nxt = SAT_MAX[ACC_W-1:0];
            else if (sum < SAT_MIN) acc_nxt = SAT_MIN[ACC_W-1:0];
            else                    acc_nxt = sum[ACC_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc <= '0;
        else     acc <= acc_nxt;
    end

    // threshold sees the post-update sum so the result can be captured on the accepting edge
    assign neg  = acc_nxt[ACC_W-1];
    assign zero = (acc_nxt == '0);
endmodule

module hv_binarizer #(
    parameter int DIM   = 32,
    parameter int ACC_W = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               acc_start,
    input  logic               acc_valid,
    input  logic               acc_last,
    input  logic [2*DIM-1:0]   sel_vec,
    output logic [DIM-1:0]     bin_bits,
    output logic               bin_valid,
    output logic [CNT_W-1:0]   bin_count,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;

    state_t             state, state_nxt;
    logic               clr, add, emit_load;
    logic [CNT_W-1:0]   cnt, cnt_base, cnt_nxt;
    logic [DIM-1:0]     neg, zero, tie, bits_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        add       = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                if (acc_start) begin
                    clr       = 1'b1;
                    state_nxt = ACCUM;
                end
                if (acc_valid && (acc_start || state == ACCUM)) begin
                    add = 1'b1;
                    if (acc_last) state_nxt = EMIT;
                end
            end
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign emit_load = add && acc_last;
    assign bin_valid = (state == EMIT);
    assign busy      = (state != IDLE);

    always_comb begin
        cnt_base = clr ? '0 : cnt;
        cnt_nxt  = cnt_base;
        if (add && cnt_base != '1) cnt_nxt = cnt_base + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= cnt_nxt;
    end

    for (genvar i = 0; i < DIM; i++) begin : g_lane
        hv_binarizer_lane #(.ACC_W(ACC_W)) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clr  (clr),
            .add  (add),
            .code (sel_vec[2*i+1:2*i]),
            .neg  (neg[i]),
            .zero (zero[i])
        );
    end

`ifdef HV_BIN_TIE_LFSR_EN
    logic [15:0] lfsr, lfsr_nxt;

    // steps once per emitted bundle; the stepped value is the one used for that bundle's ties
    assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            lfsr <= 16'hACE1;
        else if (emit_load) lfsr <= lfsr_nxt;
    end

    for (genvar i = 0; i < DIM; i++) begin : g_tie
        assign tie[i] = lfsr_nxt[i % 16];
    end
`else
    assign tie = '0;
`endif

    assign bits_nxt = (zero & tie) | (~zero & neg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_bits  <= '0;
            bin_count <= '0;
        end else if (emit_load) begin
            bin_bits  <= bits_nxt;
            bin_count <= cnt_nxt;
        end
    end
endmodule

// File: tb/tb_hv_binarizer.sv
// Directed bench for hv_binarizer at DIM=4, ACC_W=4; tie expectations follow HV_BIN_TIE_LFSR_EN.

module tb_hv_binarizer;
    localparam int DIM   = 4;
    localparam int ACC_W = 4;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               acc_start = 1'b0;
    logic               acc_valid = 1'b0;
    logic               acc_last  = 1'b0;
    logic [2*DIM-1:0]   sel_vec   = '0;
    logic [DIM-1:0]     bin_bits;
    logic               bin_valid;
    logic [CNT_W-1:0]   bin_count;
    logic               busy;

    int          total  = 0;
    int          bad    = 0;
    int          pulses = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    hv_binarizer #(.DIM(DIM), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .acc_start (acc_start),
        .acc_valid (acc_valid),
        .acc_last  (acc_last),
        .sel_vec   (sel_vec),
        .bin_bits  (bin_bits),
        .bin_valid (bin_valid),
        .bin_count (bin_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bin_valid) pulses++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] enc(input int v);
        case (v)
            1:       enc = 2'b01;
            -1:      enc = 2'b11;
            2:       enc = 2'b10;
            default: enc = 2'b00;
        endcase
    endfunction

    function automatic logic [7:0] vec(input int l0, input int l1, input int l2, input int l3);
        vec = {enc(l3), enc(l2), enc(l1), enc(l0)};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic item(input logic s, input logic v, input logic l, input logic [7:0] sv);
        acc_start = s; acc_valid = v; acc_last = l; sel_vec = sv;
        cyc();
        acc_start = 0; acc_valid = 0; acc_last = 0; sel_vec = '0;
    endtask

    // expected tie bits for the next emitted bundle, restricted to zero-sum lanes
    task automatic tie(input logic [3:0] mask, output logic [3:0] t);
`ifdef HV_BIN_TIE_LFSR_EN
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        t = m_lfsr[3:0] & mask;
`else
        t = '0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        m_lfsr = 16'hACE1;
    endtask

    initial begin
        logic [3:0] t;
        int p0;

        #12;
        chk("rst_valid", bin_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_bits",  bin_bits, 0);
        chk("rst_count", bin_count, 0);
        rst = 1'b0;
        cyc();

        // three-item bundle, lane2 sees an illegal code that must count as zero
        item(1, 1, 0, vec( 1, -1, 0, -1));
        chk("t2_busy", busy, 1);
        item(0, 1, 0, vec( 1, -1, 2, -1));
        item(0, 1, 1, vec(-1,  1, 0, -1));
        tie(4'b0100, t);
        chk("t2_valid", bin_valid, 1);
        chk("t2_bits",  bin_bits, 4'b1010 | t);
        chk("t2_count", bin_count, 3);
        cyc();
        chk("t2_valid_off", bin_valid, 0);
        chk("t2_busy_off",  busy, 0);
        chk("t2_hold",      bin_bits, 4'b1010 | t);
        chk("t2_pulses",    pulses, 1);

        // asynchronous reset in the middle of a cycle
        #3;
        rst = 1'b1;
        #1;
        chk("arst_bits",  bin_bits, 0);
        chk("arst_count", bin_count, 0);
        chk("arst_busy",  busy, 0);
        #2;
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        cyc();

        // saturation: 10x +1 clamps at 7, then 8x -1 lands at -1
        item(1, 1, 0, vec(1, 0, 0, 0));
        for (int i = 0; i < 9; i++) item(0, 1, 0, vec(1, 0, 0, 0));
        for (int i = 0; i < 7; i++) item(0, 1, 0, vec(-1, 0, 0, 0));
        p0 = pulses;
        item(0, 1, 1, vec(-1, 0, 0, 0));
        tie(4'b1110, t);
        chk("t3_valid", bin_valid, 1);
        chk("t3_bits",  bin_bits, 4'b0001 | t);
        chk("t3_count", bin_count, 18);
        chk("t3_no_early", p0, 1);
        cyc();

        // restart abandons the first bundle
        p0 = pulses;
        item(1, 1, 0, vec(-1, 0, 0, 0));
        for (int i = 0; i < 4; i++) item(0, 1, 0, vec(-1, 0, 0, 0));
        item(1, 1, 0, vec(1, 0, 0, 0));
        item(0, 1, 1, vec(1, 0, 0, 0));
        tie(4'b1110, t);
        chk("t4_valid", bin_valid, 1);
        chk("t4_bits",  bin_bits, 4'b0000 | t);
        chk("t4_count", bin_count, 2);
        cyc();
        chk("t4_pulses", pulses, p0 + 1);

        // reset after two accepted items
        p0 = pulses;
        item(1, 1, 0, vec(-1, -1, -1, -1));
        item(0, 1, 0, vec(-1, -1, -1, -1));
        do_reset();
        cyc();
        cyc();
        chk("t5_rst_busy",   busy, 0);
        chk("t5_rst_bits",   bin_bits, 0);
        chk("t5_rst_pulses", pulses, p0);

        // valid+last in IDLE is ignored
        item(0, 1, 1, vec(-1, -1, -1, -1));
        chk("t5_idle_busy", busy, 0);
        cyc();
        chk("t5_idle_valid",  bin_valid, 0);
        chk("t5_idle_pulses", pulses, p0);

        // single-item bundle
        item(1, 1, 1, vec(-1, 0, 0, 0));
        tie(4'b1110, t);
        chk("t5_one_valid", bin_valid, 1);
        chk("t5_one_bits",  bin_bits, 4'b0001 | t);
        chk("t5_one_count", bin_count, 1);
        cyc();

        // all-zero bundle from a fresh LFSR; inputs during EMIT are ignored
        do_reset();
        cyc();
        p0 = pulses;
        item(1, 1, 0, vec(0, 0, 0, 0));
        item(0, 1, 1, vec(0, 0, 0, 0));
        tie(4'b1111, t);
        chk("t6_valid", bin_valid, 1);
`ifdef HV_BIN_TIE_LFSR_EN
        chk("t6_bits", bin_bits, 4'b0011);
`else
        chk("t6_bits", bin_bits, 4'b0000);
`endif
        chk("t6_count", bin_count, 2);
        item(1, 1, 1, vec(-1, -1, -1, -1));
        chk("t6_emit_ign_busy", busy, 0);
        chk("t6_emit_ign_bits", bin_bits, t);
        cyc();
        chk("t6_emit_ign_valid",  bin_valid, 0);
        chk("t6_emit_ign_pulses", pulses, p0 + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
